// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding, counter width and STABLE_CYCLES limit for debounce_pulse
package debounce_pkg;
    localparam int STAB_W     = 8;
    localparam int STABLE_MAX = 255;
    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_e;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer, both stages cleared by synchronous active-low reset
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);
    logic s1_q, s2_q;
    // shift the raw input through two flops to settle metastability
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= in;
            s2_q <= s1_q;
        end
    end
    assign out = s2_q;
endmodule

// File: rtl/debounce_pulse.sv
// debounce_pulse: debounced level with rise/fall pulses and rising-edge counter; DEBOUNCE_SYNC_EN adds a 2-flop input synchronizer
module debounce_pulse
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] events
);
    localparam int STABLE = (STABLE_CYCLES < 1) ? 1 :
                            (STABLE_CYCLES > STABLE_MAX) ? STABLE_MAX : STABLE_CYCLES;
    // the sample being taken counts toward the run, so acceptance happens when STABLE-1 are already counted
    localparam logic [STAB_W-1:0] LAST = STAB_W'(STABLE - 1);

    logic d_s;
`ifdef DEBOUNCE_SYNC_EN
    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .in    (d),
        .out   (d_s)
    );
`else
    assign d_s = d;
`endif

    state_e            state_q, state_d;
    logic [STAB_W-1:0] cnt_q, cnt_d;
    logic              level_q, level_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic [CNT_W-1:0]  events_q, events_d;
    logic              lo_side;
    logic              change;

    // lo_side: accepted level is 0; change: the current sample differs from the accepted level
    assign lo_side = (state_q == IDLE_LO) || (state_q == WAIT_HI);
    assign change  = (d_s == lo_side);

    // next-state: a run of differing samples counts up; a matching sample aborts it; reaching STABLE accepts it
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        events_d = events_q;
        if (!change) begin
            state_d = lo_side ? IDLE_LO : IDLE_HI;
            cnt_d   = '0;
        end else if (cnt_q >= LAST) begin
            state_d  = lo_side ? IDLE_HI : IDLE_LO;
            cnt_d    = '0;
            level_d  = lo_side;
            rise_d   = lo_side;
            fall_d   = !lo_side;
            events_d = events_q + CNT_W'(lo_side);
        end else begin
            state_d = lo_side ? WAIT_HI : WAIT_LO;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    // state and output registers; reset aborts any pending qualification without pulsing
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE_LO;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            events_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            events_q <= events_d;
        end
    end

    assign level  = level_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign events = events_q;
endmodule

// File: tb/tb_debounce_pulse.sv
// tb_debounce_pulse: randomized scoreboard bench for debounce_pulse against a sliding-window reference model
module tb_debounce_pulse;
    localparam int N = 4;

    typedef struct packed {
        logic       level;
        logic       rise;
        logic       fall;
        logic [7:0] events;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       d = 1'b0;
    logic       level, rise, fall;
    logic [7:0] events;

    exp_t q[$];
    int   total = 0;
    int   passed = 0;

    bit       hist[$];
    bit       m_level = 1'b0;
    bit [7:0] m_events = 8'd0;
    bit       s1 = 1'b0, s2 = 1'b0;

    always #10 clk = ~clk;

    debounce_pulse #(.STABLE_CYCLES(N), .CNT_W(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .d      (d),
        .level  (level),
        .rise   (rise),
        .fall   (fall),
        .events (events)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        else passed++;
    endtask

    // reference: level flips once the last N samples since reset all disagree with it
    task automatic model_edge(input bit rst_n, input bit din, output exp_t e);
        bit x;
        bit all;
`ifdef DEBOUNCE_SYNC_EN
        x = s2;
        if (!rst_n) begin s1 = 1'b0; s2 = 1'b0; end
        else begin s2 = s1; s1 = din; end
`else
        x = din;
`endif
        e.rise = 1'b0;
        e.fall = 1'b0;
        if (!rst_n) begin
            hist.delete();
            m_level = 1'b0;
            m_events = 8'd0;
        end else begin
            hist.push_back(x);
            if (hist.size() > N) void'(hist.pop_front());
            all = (hist.size() == N);
            foreach (hist[i]) if (hist[i] == m_level) all = 1'b0;
            if (all) begin
                m_level = !m_level;
                if (m_level) begin e.rise = 1'b1; m_events = m_events + 8'd1; end
                else e.fall = 1'b1;
                hist.delete();
            end
        end
        e.level = m_level;
        e.events = m_events;
    endtask

    task automatic step(input bit rst_n, input bit din);
        exp_t e;
        reset = rst_n;
        d = din;
        model_edge(rst_n, din, e);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic hold(input bit v, input int n);
        repeat (n) step(1'b1, v);
    endtask

    // monitor: every rising edge the DUT presents a registered result; pop and compare just after it
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                total++;
                $display("FAIL scoreboard_underflow at %0t", $time);
            end else begin
                e = q.pop_front();
                chk("level", {7'd0, level}, {7'd0, e.level});
                chk("rise", {7'd0, rise}, {7'd0, e.rise});
                chk("fall", {7'd0, fall}, {7'd0, e.fall});
                chk("events", events, e.events);
                chk("rise_and_fall", {7'd0, rise & fall}, 8'd0);
            end
        end
    end

    initial begin
        bit cur;
        repeat (3) step(1'b0, 1'b0);
        hold(1'b0, 10);
        hold(1'b1, 8);
        hold(1'b0, 8);
        hold(1'b1, 3);
        hold(1'b0, 6);
        hold(1'b1, 8);
        hold(1'b0, 3);
        hold(1'b1, 6);
        hold(1'b0, 8);
        hold(1'b1, 2);
        step(1'b0, 1'b1);
        hold(1'b1, 8);
        hold(1'b0, 8);
        repeat (260) begin
            hold(1'b1, int'($urandom_range(4, 7)));
            hold(1'b0, int'($urandom_range(4, 7)));
        end
        cur = 1'b0;
        repeat (3000) begin
            if ($urandom_range(0, 3) == 0) cur = !cur;
            step($urandom_range(0, 49) != 0, cur);
        end
        hold(1'b0, 2);
        chk("queue_drained", 8'(q.size()), 8'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/debounce_pulse.md
DEBOUNCE_PULSE -- requirements
Module: debounce_pulse

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive sampled cycles an input change must persist before acceptance; legal range 1..255.
REQ-002 Parameter CNT_W, default 8: width of the rising-edge event counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset sampled on rising clk.
REQ-005 d  input  1  raw single-bit level from the upstream registered flip-flop stage.
REQ-006 level  output  1  debounced, registered copy of d.
REQ-007 rise  output  1  one-cycle pulse on accepted 0->1 transition of level.
REQ-008 fall  output  1  one-cycle pulse on accepted 1->0 transition of level.
REQ-009 events  output  CNT_W  count of accepted rising transitions.

Function
REQ-010 The FSM SHALL have four states: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO.
REQ-011 IDLE_LO: d=0 stays; d=1 -> WAIT_HI with stability counter loaded to 1.
REQ-012 WAIT_HI: d=1 and counter=STABLE_CYCLES -> IDLE_HI; d=1 otherwise counter+1; d=0 -> IDLE_LO, counter cleared, no pulse.
REQ-013 IDLE_HI and WAIT_LO SHALL mirror REQ-011/012 with polarity inverted.
REQ-014 STABLE_CYCLES=1 SHALL accept a change on the first cycle it is sampled, bypassing the WAIT state.
REQ-015 level SHALL change on the clock edge of the STABLE_CYCLES-th consecutive sample of the new value; glitches shorter than STABLE_CYCLES samples SHALL never reach level.
REQ-016 rise (fall) SHALL be high for exactly the one cycle in which level first reads 1 (0); rise and fall SHALL never be high together.
REQ-017 events SHALL increment by 1 in the same edge that sets rise, wrapping from 2^CNT_W-1 to 0 without flag.
REQ-018 The stability counter SHALL be wide enough for 255 and SHALL never exceed STABLE_CYCLES.
REQ-019 All outputs SHALL be driven directly from registers; no combinational path d -> outputs.

Reset
REQ-020 When reset=0 at a rising edge: state=IDLE_LO, counter=0, level=0, rise=0, fall=0, events=0.
REQ-021 Reset asserted during WAIT_HI or WAIT_LO SHALL abort the pending transition with no pulse and no events change.
REQ-022 After reset deasserts with d already 1, a full STABLE_CYCLES qualification SHALL occur before rise.

Configuration
REQ-023 Macro DEBOUNCE_SYNC_EN defined: d SHALL pass through a two-flop synchronizer, reset to 0, before the FSM, adding exactly 2 cycles to every latency.
REQ-024 Macro DEBOUNCE_SYNC_EN undefined: d SHALL feed the FSM directly; latency as in REQ-015.

Structure
REQ-025 Shared package debounce_pkg SHALL hold the state encoding constants, the 8-bit counter width constant, and the STABLE_CYCLES upper limit.
REQ-026 The synchronizer SHALL be the sub-module sync_2ff (clk, reset, in, out), instantiated only under DEBOUNCE_SYNC_EN.

Verification (20 ns clock, STABLE_CYCLES=4, macro undefined unless stated)
REQ-027 Reset held low 3 cycles then released, d=0 for 10 cycles -> level=0, rise=fall=0, events=0 throughout.
REQ-028 d=1 held from edge k -> level=1 and rise=1 at edge k+3, rise=0 at k+4, events=1.
REQ-029 d=1 for 3 cycles then 0 -> level stays 0, no rise, events unchanged.
REQ-030 level=1, d=0 held 4 cycles -> fall pulses exactly once, level=0; 256 accepted rises from events=0 -> events returns to 0.
REQ-031 d=1 for 2 cycles, reset low 1 cycle, d held 1 -> no pulse during abort, rise exactly 4 cycles after reset release.
REQ-032 DEBOUNCE_SYNC_EN defined, repeat REQ-028 stimulus -> rise at edge k+5.
